// File: rtl/xspi_csr_slave_if.sv
// CSR-side bus of the xSPI slave. The serial front end drives it through the master modport,
// and the register file answers through the slave modport.
interface xspi_csr_slave_if #(
  parameter int unsigned A_WIDTH = 5
) ();
  logic               chip_select;
  logic [A_WIDTH-1:0] csr_address;
  logic               csr_read;
  logic               csr_write;
  logic [7:0]         csr_writedata;
  logic [7:0]         csr_readdata;

  modport master (
    output chip_select, csr_address, csr_read, csr_write, csr_writedata,
    input  csr_readdata
  );

  modport slave (
    input  chip_select, csr_address, csr_read, csr_write, csr_writedata,
    output csr_readdata
  );
endinterface

// File: rtl/xspi_csr_slave.sv
// Mode-0 multi-lane serial slave bridging to an 8-bit CSR bus; sck/nss are oversampled by clk.
// Optional macro CD_XSPI_ADDR_INC_EN: csr_address auto-increments after each data-byte strobe.
module xspi_csr_slave #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sck,
  input  logic             nss,
  input  logic [LANES-1:0] sdi,
  output logic [LANES-1:0] sdo,
  output logic             sdo_oe,
  xspi_csr_slave_if.master csr
);

  localparam int unsigned Steps    = 8 / LANES;
  localparam logic [2:0]  LastStep = 3'(Steps - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StWdata, StRdata} state_e;
  state_e state_q, state_d;

  logic             sck_s1, sck_s2, sck_s3;
  logic             nss_s1, nss_s2, nss_s3;
  logic [LANES-1:0] sdi_s1, sdi_s2;
  logic             init_q, armed_q;

  logic             nss_rise, nss_fall, sck_rise, sck_fall, byte_done;
  logic             cmd_done, wr_done, rd_issue, tx_shift;
  logic [2:0]       cnt_q;
  logic [7:0]       rx_q, rx_byte, wbuf_q, wdata_q, tx_q;
  logic             wr_pend_q, write_q, read_q, rd_cap_q, cs_q, oe_q;
  logic [LANES-1:0] sdo_q;
  logic [A_WIDTH-1:0] addr_q;
  logic             unused_cmd_bits;

  // nss resets high so reset release never looks like a frame start; armed_q additionally
  // requires nss to be seen high once, so a frame caught mid-way by reset is skipped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sck_s1  <= 1'b0;
      sck_s2  <= 1'b0;
      sck_s3  <= 1'b0;
      nss_s1  <= 1'b1;
      nss_s2  <= 1'b1;
      nss_s3  <= 1'b1;
      sdi_s1  <= '0;
      sdi_s2  <= '0;
      init_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_s3  <= sck_s2;
      nss_s1  <= nss;
      nss_s2  <= nss_s1;
      nss_s3  <= nss_s2;
      sdi_s1  <= sdi;
      sdi_s2  <= sdi_s1;
      init_q  <= 1'b1;
      armed_q <= armed_q | (init_q & nss_s1);
    end
  end

  // A frame end beats any sck edge seen in the same clk.
  assign nss_rise  = nss_s2 & ~nss_s3;
  assign nss_fall  = ~nss_s2 & nss_s3 & armed_q;
  assign sck_rise  = sck_s2 & ~sck_s3 & ~nss_rise;
  assign sck_fall  = ~sck_s2 & sck_s3 & ~nss_rise;
  assign byte_done = sck_rise & (cnt_q == LastStep);
  assign rx_byte   = {rx_q[7-LANES:0], sdi_s2};
  assign unused_cmd_bits = ^(rx_byte[6:0] >> A_WIDTH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (nss_fall) state_d = StCmd;
      StCmd: begin
        if (nss_rise)       state_d = StIdle;
        else if (byte_done) state_d = rx_byte[7] ? StWdata : StRdata;
      end
      StWdata: if (nss_rise) state_d = StIdle;
      StRdata: if (nss_rise) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_done = 1'b0;
    wr_done  = 1'b0;
    rd_issue = 1'b0;
    tx_shift = 1'b0;
    unique case (state_q)
      StCmd: begin
        cmd_done = byte_done;
        rd_issue = byte_done & ~rx_byte[7];
      end
      StWdata: wr_done = byte_done;
      StRdata: begin
        rd_issue = byte_done;
        tx_shift = sck_fall;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rx_q      <= '0;
      wr_pend_q <= 1'b0;
      wbuf_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      rd_cap_q  <= 1'b0;
      tx_q      <= '0;
      sdo_q     <= '0;
      oe_q      <= 1'b0;
      cs_q      <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (nss_rise || state_q == StIdle) cnt_q <= '0;
      else if (sck_rise)                 cnt_q <= byte_done ? 3'd0 : cnt_q + 3'd1;
      if (sck_rise && state_q != StIdle) rx_q <= rx_byte;

      // Write strobe lands two clks after the completing rise: buffer, then strobe.
      wr_pend_q <= wr_done;
      if (wr_done) wbuf_q <= rx_byte;
      write_q   <= wr_pend_q;
      if (wr_pend_q) wdata_q <= wbuf_q;

      read_q   <= rd_issue;
      rd_cap_q <= read_q;
      if (rd_cap_q)      tx_q <= csr.csr_readdata;
      else if (tx_shift) tx_q <= tx_q << LANES;

      if (nss_rise) begin
        sdo_q <= '0;
        oe_q  <= 1'b0;
      end else if (tx_shift) begin
        sdo_q <= tx_q[7 -: LANES];
        oe_q  <= 1'b1;
      end

      if (nss_rise)      cs_q <= 1'b0;
      else if (cmd_done) cs_q <= 1'b1;

      if (cmd_done) addr_q <= rx_byte[A_WIDTH-1:0];
`ifdef CD_XSPI_ADDR_INC_EN
      else if (write_q || read_q) addr_q <= addr_q + 1'b1;
`endif
    end
  end

  assign sdo               = sdo_q;
  assign sdo_oe            = oe_q;
  assign csr.chip_select   = cs_q;
  assign csr.csr_address   = addr_q;
  assign csr.csr_read      = read_q;
  assign csr.csr_write     = write_q;
  assign csr.csr_writedata = wdata_q;

endmodule

// File: doc/xspi_csr_slave.md
XSPI_CSR_SLAVE -- requirements
Module: xspi_csr_slave

Interface
REQ-001 Parameter LANES, default 4, data lanes per SCK edge; legal values 1, 2, 4.
REQ-002 Parameter A_WIDTH, default 5, CSR address width; legal range 1..7.
REQ-003 clk  input  1  single system clock; every register is clocked by it.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 sck  input  1  serial clock from the host; asynchronous to clk.
REQ-006 nss  input  1  active-low frame select; asynchronous to clk.
REQ-007 sdi  input  LANES  serial data in; lane LANES-1 carries the most significant bit of each step.
REQ-008 sdo  output  LANES  serial data out.
REQ-009 sdo_oe  output  1  output enable for the sdo pads.
REQ-010 chip_select  output  1  high while a frame is addressed to the CSR bus.
REQ-011 csr_address  output  A_WIDTH  CSR address.
REQ-012 csr_read, csr_write  output  1 each  single-cycle strobes.
REQ-013 csr_writedata  output  8  write data.
REQ-014 csr_readdata  input  8  read data, valid 1 clk after csr_read.

Function
REQ-015 sck and nss SHALL each pass a 2-flop synchroniser; edges SHALL be detected in the clk domain; f_clk >= 8 x f_sck is required.
REQ-016 Mode 0 timing: sdi is sampled on the synchronised sck rise; sdo is updated on the synchronised sck fall; bytes are transferred MSB first over 8/LANES steps.
REQ-017 FSM states: IDLE, CMD, WDATA, RDATA.
REQ-018 IDLE->CMD on the nss fall, which also clears the step counter.
REQ-019 On command-byte completion, bit7=1 SHALL select WDATA and bit7=0 SHALL select RDATA.
REQ-020 Command bits[A_WIDTH-1:0] SHALL load csr_address; bits [6:A_WIDTH] SHALL be ignored.
REQ-021 chip_select SHALL rise in the clk after command-byte completion and fall on the nss rise.
REQ-022 WDATA: each completed byte SHALL drive csr_writedata and pulse csr_write for 1 clk, exactly 2 clks after the completing sck rise is detected.
REQ-023 RDATA: csr_read SHALL pulse on completion of the command byte and of every read byte.
REQ-024 RDATA: csr_readdata SHALL be captured 1 clk after csr_read and loaded into the shift register before the next sck fall.
REQ-025 RDATA: sdo_oe SHALL be high from the first sck fall until the nss rise.
REQ-026 The prefetch read issued on the final read byte SHALL still be performed if the host ends the frame there; its data is discarded.
REQ-027 An nss rise in any state SHALL discard a partial byte with no strobe, return the FSM to IDLE, and deassert sdo_oe and chip_select within 3 clks.
REQ-028 An nss rise during IDLE or CMD SHALL produce no CSR access.
REQ-029 When an sck edge and an nss rise are detected in the same clk, nss SHALL win and the edge SHALL be ignored.
REQ-030 csr_read and csr_write SHALL never be asserted together.

Reset
REQ-031 The following outputs SHALL be 0 during reset: sdo, sdo_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata.
REQ-032 During reset the FSM SHALL be in IDLE and the counters and synchronisers SHALL hold 0 (nss synchroniser reset value 1).
REQ-033 Reset asserted mid-frame SHALL abort the frame; after release, the block SHALL wait for a fresh nss fall.

Configuration
REQ-034 With macro CD_XSPI_ADDR_INC_EN defined, csr_address SHALL increment by 1 after each data-byte strobe and wrap modulo 2^A_WIDTH.
REQ-035 Without CD_XSPI_ADDR_INC_EN, csr_address SHALL stay fixed for the whole frame (FIFO-style registers).

Verification
REQ-036 LANES=4: bytes 0x85, 0x3C -> one csr_write, address 5, data 0x3C, chip_select high.
REQ-037 LANES=1: command 0x02, then 2 bytes read with csr_readdata=0xA5 then 0x5A -> sdo carries 0xA5 then 0x5A; 3 csr_read pulses total.
REQ-038 INC_EN, A_WIDTH=5: command 0x9F, then writes 0x11, 0x22 -> writes at addresses 31 then 0.
REQ-039 No INC_EN: command 0x83, then writes 0x01, 0x02, 0x03 -> 3 writes, all at address 3.
REQ-040 LANES=2: nss rises after 2 of the 4 data steps -> no csr_write; FSM in IDLE; sdo_oe 0.
REQ-041 reset_n low mid-RDATA -> all outputs 0 at once; the next frame (0x81, 0x77) writes 0x77 to address 1.
